// File: rtl/wb_i2c_slave.sv
// I2C target with a byte-addressed register memory shared with a Wishbone slave port.
// Optional SCL/SDA majority filter: define I2C_SLAVE_GLITCH_FILTER_EN.
`timescale 1ns/1ps
module wb_i2c_slave #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned MEM_AW     = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  input  logic        scl_pad_i,
  input  logic        sda_pad_i,
  output logic        sda_pad_o,
  output logic        sda_padoen_o,
  output logic        irq_o
);

  localparam int unsigned Depth = 2 ** MEM_AW;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StAddr     = 3'd1,
    StAddrAck  = 3'd2,
    StWrByte   = 3'd3,
    StWrAck    = 3'd4,
    StRdByte   = 3'd5,
    StRdAck    = 3'd6,
    StWaitStop = 3'd7
  } state_e;

  state_e state_q, state_d;

  logic [1:0]        scl_sync_q, sda_sync_q;
  logic              scl_s, sda_s;
  logic              scl_prev_q, sda_prev_q;
  logic              scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]        sr_q;
  logic [3:0]        cnt_q;
  logic [MEM_AW-1:0] ptr_q;
  logic              rw_q, first_q, wrote_q, ack_ok_q, irq_q;
  logic              i2c_we, drive_low;
  logic              wb_ack_q, wb_req, wb_wr;
  logic [31:0]       wb_dat_q;
  logic [MEM_AW-1:0] wb_off;
  logic [7:0]        mem [Depth];
  logic              unused_bits;

  assign unused_bits = ^{wb_adr_i[31:MEM_AW+2], wb_adr_i[1:0], wb_dat_i[31:8]};

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_pad_i};
      sda_sync_q <= {sda_sync_q[0], sda_pad_i};
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  logic [1:0] scl_hist_q, sda_hist_q;
  logic       scl_filt_q, sda_filt_q;

  // Output follows the line only once three consecutive samples agree.
  assign scl_s = (&{scl_hist_q, scl_sync_q[1]})  ? 1'b1 :
                 (~|{scl_hist_q, scl_sync_q[1]}) ? 1'b0 : scl_filt_q;
  assign sda_s = (&{sda_hist_q, sda_sync_q[1]})  ? 1'b1 :
                 (~|{sda_hist_q, sda_sync_q[1]}) ? 1'b0 : sda_filt_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      scl_hist_q <= 2'b11;
      sda_hist_q <= 2'b11;
      scl_filt_q <= 1'b1;
      sda_filt_q <= 1'b1;
    end else begin
      scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
      sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
      scl_filt_q <= scl_s;
      sda_filt_q <= sda_s;
    end
  end
`else
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_prev_q <= scl_s;
      sda_prev_q <= sda_s;
    end
  end

  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  // Data byte commit: first byte after the address is the pointer, not data.
  assign i2c_we = (state_q == StWrByte) & scl_fall & (cnt_q == 4'd8) & ~first_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = StAddr;
    end else if (stop_det) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: ;
        StAddr: begin
          if (scl_fall && cnt_q == 4'd8) begin
            state_d = (sr_q[7:1] == SLAVE_ADDR) ? StAddrAck : StWaitStop;
          end
        end
        StAddrAck: if (scl_fall) state_d = rw_q ? StRdByte : StWrByte;
        StWrByte:  if (scl_fall && cnt_q == 4'd8) state_d = StWrAck;
        StWrAck:   if (scl_fall) state_d = StWrByte;
        StRdByte:  if (scl_fall && cnt_q == 4'd8) state_d = StRdAck;
        StRdAck: begin
          if (scl_rise && sda_s)          state_d = StWaitStop;
          else if (scl_fall && ack_ok_q) state_d = StRdByte;
        end
        StWaitStop: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    drive_low = 1'b0;
    case (state_q)
      StAddrAck, StWrAck: drive_low = 1'b1;
      StRdByte:           drive_low = ~sr_q[7];
      default:            drive_low = 1'b0;
    endcase
  end

  assign sda_pad_o    = 1'b0;
  assign sda_padoen_o = ~drive_low;
  assign irq_o        = irq_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sr_q     <= 8'd0;
      cnt_q    <= 4'd0;
      ptr_q    <= '0;
      rw_q     <= 1'b0;
      first_q  <= 1'b0;
      wrote_q  <= 1'b0;
      ack_ok_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      irq_q <= stop_det & wrote_q;
      if (start_det) begin
        cnt_q   <= 4'd0;
        wrote_q <= 1'b0;
      end else if (stop_det) begin
        wrote_q <= 1'b0;
      end else begin
        case (state_q)
          StAddr: begin
            if (scl_rise) begin
              sr_q  <= {sr_q[6:0], sda_s};
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              rw_q    <= sr_q[0];
              first_q <= 1'b1;
            end
          end
          StAddrAck: begin
            if (scl_fall) begin
              cnt_q <= 4'd0;
              if (rw_q) sr_q <= mem[ptr_q];
            end
          end
          StWrByte: begin
            if (scl_rise) begin
              sr_q  <= {sr_q[6:0], sda_s};
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall && cnt_q == 4'd8) begin
              if (first_q) begin
                ptr_q   <= MEM_AW'(sr_q);
                first_q <= 1'b0;
              end else begin
                ptr_q   <= ptr_q + MEM_AW'(1);
                wrote_q <= 1'b1;
              end
            end
          end
          StWrAck: if (scl_fall) cnt_q <= 4'd0;
          StRdByte: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (cnt_q == 4'd8) begin
                ptr_q    <= ptr_q + MEM_AW'(1);
                ack_ok_q <= 1'b0;
              end else begin
                sr_q <= {sr_q[6:0], 1'b0};
              end
            end
          end
          StRdAck: begin
            if (scl_rise && !sda_s) begin
              ack_ok_q <= 1'b1;
            end else if (scl_fall && ack_ok_q) begin
              sr_q  <= mem[ptr_q];
              cnt_q <= 4'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Wishbone: a write colliding with an I2C commit is held off one cycle.
  assign wb_off = wb_adr_i[MEM_AW+1:2];
  assign wb_req = wb_cyc_i & wb_stb_i & ~wb_ack_q;
  assign wb_wr  = wb_req & wb_we_i & ~i2c_we;

  always_ff @(posedge wb_clk_i) begin
    if (i2c_we)     mem[ptr_q]  <= sr_q;
    else if (wb_wr) mem[wb_off] <= wb_dat_i[7:0];
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wb_ack_q <= 1'b0;
      wb_dat_q <= 32'd0;
    end else begin
      wb_ack_q <= wb_req & ~(wb_we_i & i2c_we);
      if (wb_req && !wb_we_i) wb_dat_q <= {24'd0, mem[wb_off]};
    end
  end

  assign wb_ack_o = wb_ack_q;
  assign wb_dat_o = wb_dat_q;

endmodule

// File: tb/tb_wb_i2c_slave.sv
// Directed bench for wb_i2c_slave: bit-level I2C master model plus Wishbone tasks.
`timescale 1ns/1ps
module tb_wb_i2c_slave;

  localparam int Q = 8;

  logic        clk, rst;
  logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
  logic        wb_we, wb_cyc, wb_stb, wb_ack;
  logic        scl_m, sda_m, sda_bus;
  logic        sda_o, sda_oen, irq;
  int          n_checks, n_fail, irq_cnt;

  wb_i2c_slave dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .wb_adr_i    (wb_adr),
    .wb_dat_i    (wb_dat_w),
    .wb_we_i     (wb_we),
    .wb_cyc_i    (wb_cyc),
    .wb_stb_i    (wb_stb),
    .wb_dat_o    (wb_dat_r),
    .wb_ack_o    (wb_ack),
    .scl_pad_i   (scl_m),
    .sda_pad_i   (sda_bus),
    .sda_pad_o   (sda_o),
    .sda_padoen_o(sda_oen),
    .irq_o       (irq)
  );

  assign sda_bus = sda_m & (sda_oen | sda_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (irq) irq_cnt++;

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             n_checks, n_fail);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [7:0] d);
    int t;
    @(negedge clk);
    wb_adr = adr; wb_dat_w = {24'd0, d}; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!wb_ack && t < 10);
    if (!wb_ack) begin
      n_checks++; n_fail++;
      $display("FAIL wb_write_timeout: adr=%h no ack, required ack", adr);
    end
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
  endtask

  task automatic wb_read(input logic [31:0] adr, output logic [31:0] d);
    int t;
    @(negedge clk);
    wb_adr = adr; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    t = 0;
    do begin @(negedge clk); t++; end while (!wb_ack && t < 10);
    if (!wb_ack) begin
      n_checks++; n_fail++;
      $display("FAIL wb_read_timeout: adr=%h no ack, required ack", adr);
    end
    d = wb_dat_r;
    wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_rstart();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_bit(input logic b);
    sda_m = b; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic read_bit(output logic b);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    b = sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] d);
    logic b;
    d = 8'd0;
    for (int i = 0; i < 8; i++) begin
      read_bit(b);
      d = {d[6:0], b};
    end
    write_bit(~ack);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(4);
    n_checks++; if (sda_oen !== 1'b1) begin n_fail++; $display("FAIL rst_padoen: got %b want 1", sda_oen); end
    n_checks++; if (sda_o !== 1'b0) begin n_fail++; $display("FAIL rst_pad_o: got %b want 0", sda_o); end
    n_checks++; if (wb_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", wb_ack); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL rst_irq: got %b want 0", irq); end
    n_checks++; if (wb_dat_r !== 32'd0) begin n_fail++; $display("FAIL rst_dat: got %h want 0", wb_dat_r); end
    n_checks++; if (3'(dut.state_q) !== 3'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", dut.state_q); end
    n_checks++; if (dut.ptr_q !== 8'h00) begin n_fail++; $display("FAIL rst_ptr: got %h want 00", dut.ptr_q); end
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_addr_match();
    logic [3:0]  acks;
    logic [31:0] d;
    int          irq0;
    irq0 = irq_cnt;
    i2c_start();
    write_byte(8'hA0, acks[3]);
    write_byte(8'h10, acks[2]);
    write_byte(8'h5A, acks[1]);
    write_byte(8'hC3, acks[0]);
    i2c_stop();
    tick(4);
    n_checks++; if (acks !== 4'b1111) begin n_fail++; $display("FAIL match_acks: got %b want 1111", acks); end
    n_checks++; if (irq_cnt - irq0 !== 1) begin n_fail++; $display("FAIL match_irq: got %0d pulses want 1", irq_cnt - irq0); end
    n_checks++; if (dut.ptr_q !== 8'h12) begin n_fail++; $display("FAIL match_ptr: got %h want 12", dut.ptr_q); end
    wb_read(32'h40, d);
    n_checks++; if (d !== 32'h5A) begin n_fail++; $display("FAIL match_rd10: got %h want 0000005a", d); end
    wb_read(32'h44, d);
    n_checks++; if (d !== 32'hC3) begin n_fail++; $display("FAIL match_rd11: got %h want 000000c3", d); end
  endtask

  task automatic test_read_rstart();
    logic [3:0] acks;
    logic [7:0] b0, b1;
    int         irq0;
    wb_write(32'h80, 8'h77);
    wb_write(32'h84, 8'h3C);
    irq0 = irq_cnt;
    i2c_start();
    write_byte(8'hA0, acks[3]);
    write_byte(8'h20, acks[2]);
    i2c_rstart();
    write_byte(8'hA1, acks[1]);
    acks[0] = 1'b1;
    read_byte(1'b1, b0);
    read_byte(1'b0, b1);
    n_checks++; if (acks !== 4'b1111) begin n_fail++; $display("FAIL rd_acks: got %b want 1111", acks); end
    n_checks++; if (b0 !== 8'h77) begin n_fail++; $display("FAIL rd_byte0: got %h want 77", b0); end
    n_checks++; if (b1 !== 8'h3C) begin n_fail++; $display("FAIL rd_byte1: got %h want 3c", b1); end
    n_checks++; if (3'(dut.state_q) !== 3'd7) begin n_fail++; $display("FAIL rd_waitstop: got %0d want 7", dut.state_q); end
    i2c_stop();
    tick(4);
    n_checks++; if (3'(dut.state_q) !== 3'd0) begin n_fail++; $display("FAIL rd_idle: got %0d want 0", dut.state_q); end
    n_checks++; if (dut.ptr_q !== 8'h22) begin n_fail++; $display("FAIL rd_ptr: got %h want 22", dut.ptr_q); end
    n_checks++; if (irq_cnt !== irq0) begin n_fail++; $display("FAIL rd_irq: got %0d pulses want 0", irq_cnt - irq0); end
  endtask

  task automatic test_addr_mismatch();
    logic [2:0]  acks;
    logic [31:0] d;
    int          irq0;
    irq0 = irq_cnt;
    i2c_start();
    write_byte(8'hA2, acks[2]);
    write_byte(8'h10, acks[1]);
    write_byte(8'hEE, acks[0]);
    i2c_stop();
    tick(4);
    n_checks++; if (acks !== 3'b000) begin n_fail++; $display("FAIL mis_acks: got %b want 000", acks); end
    n_checks++; if (irq_cnt !== irq0) begin n_fail++; $display("FAIL mis_irq: got %0d pulses want 0", irq_cnt - irq0); end
    wb_read(32'h40, d);
    n_checks++; if (d !== 32'h5A) begin n_fail++; $display("FAIL mis_mem: got %h want 0000005a", d); end
  endtask

  task automatic test_wrap();
    logic [3:0]  acks;
    logic [31:0] d;
    int          irq0;
    irq0 = irq_cnt;
    i2c_start();
    write_byte(8'hA0, acks[3]);
    write_byte(8'hFF, acks[2]);
    write_byte(8'h11, acks[1]);
    write_byte(8'h22, acks[0]);
    i2c_stop();
    tick(4);
    n_checks++; if (acks !== 4'b1111) begin n_fail++; $display("FAIL wrap_acks: got %b want 1111", acks); end
    n_checks++; if (dut.ptr_q !== 8'h01) begin n_fail++; $display("FAIL wrap_ptr: got %h want 01", dut.ptr_q); end
    n_checks++; if (irq_cnt - irq0 !== 1) begin n_fail++; $display("FAIL wrap_irq: got %0d pulses want 1", irq_cnt - irq0); end
    wb_read(32'h3FC, d);
    n_checks++; if (d !== 32'h11) begin n_fail++; $display("FAIL wrap_memff: got %h want 00000011", d); end
    wb_read(32'h0, d);
    n_checks++; if (d !== 32'h22) begin n_fail++; $display("FAIL wrap_mem00: got %h want 00000022", d); end
  endtask

  task automatic test_collision();
    logic [2:0]  acks;
    logic [7:0]  v;
    logic        b, found;
    int          n;
    logic [31:0] d;
    v = 8'h44;
    i2c_start();
    write_byte(8'hA0, acks[2]);
    write_byte(8'h05, acks[1]);
    for (int i = 7; i >= 1; i--) write_bit(v[i]);
    sda_m = v[0]; tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      found = dut.i2c_we;
    end
    wb_adr = 32'h14; wb_dat_w = 32'h99; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!wb_ack && n < 6);
    wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL col_commit: got %b want 1", found); end
    n_checks++; if (n !== 2) begin n_fail++; $display("FAIL col_ack_lat: got %0d cycles want 2", n); end
    tick(Q);
    read_bit(b);
    acks[0] = ~b;
    i2c_stop();
    tick(4);
    n_checks++; if (acks !== 3'b111) begin n_fail++; $display("FAIL col_acks: got %b want 111", acks); end
    wb_read(32'h14, d);
    n_checks++; if (d !== 32'h99) begin n_fail++; $display("FAIL col_mem: got %h want 00000099", d); end
  endtask

  task automatic test_reset_mid_read();
    logic [2:0] acks;
    logic       b, a;
    wb_write(32'hC0, 8'h00);
    i2c_start();
    write_byte(8'hA0, acks[2]);
    write_byte(8'h30, acks[1]);
    i2c_rstart();
    write_byte(8'hA1, acks[0]);
    for (int i = 0; i < 4; i++) read_bit(b);
    sda_m = 1'b1; tick(Q);
    n_checks++; if (sda_oen !== 1'b0) begin n_fail++; $display("FAIL mid_pre_drive: got %b want 0", sda_oen); end
    rst = 1'b1;
    tick(1);
    n_checks++; if (sda_oen !== 1'b1) begin n_fail++; $display("FAIL mid_release: got %b want 1", sda_oen); end
    n_checks++; if (3'(dut.state_q) !== 3'd0) begin n_fail++; $display("FAIL mid_state: got %0d want 0", dut.state_q); end
    n_checks++; if (dut.ptr_q !== 8'h00) begin n_fail++; $display("FAIL mid_ptr: got %h want 00", dut.ptr_q); end
    rst = 1'b0;
    tick(4);
    i2c_rstart();
    write_byte(8'hA0, a);
    i2c_stop();
    tick(4);
    n_checks++; if (acks !== 3'b111) begin n_fail++; $display("FAIL mid_setup_acks: got %b want 111", acks); end
    n_checks++; if (a !== 1'b1) begin n_fail++; $display("FAIL mid_new_ack: got %b want 1", a); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; irq_cnt = 0;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    wb_adr = 32'd0; wb_dat_w = 32'd0; wb_we = 1'b0; wb_cyc = 1'b0; wb_stb = 1'b0;
    test_reset();
    test_addr_match();
    test_read_rstart();
    test_addr_mismatch();
    test_wrap();
    test_collision();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_i2c_slave.md
# wb_i2c_slave

I2C responder (target) with a byte-addressed register memory, the far end of the `i2c_master_top` controllers on the QSFP buses. It decodes START/STOP, matches a 7-bit address and ACKs it, then serves pointer-based writes and reads in QSFP/EEPROM style. A Wishbone slave port gives the CPU read/write access to the same memory. It serves as the on-chip QSFP management-interface emulator for simulation and board loopback tests.

## Interface
- `SLAVE_ADDR`, 7'h50: 7-bit I2C address this responder answers to.
- `MEM_AW`, 8: memory address width; depth is 2^MEM_AW bytes.
- `wb_clk_i` in 1: system clock; all logic runs on the rising edge.
- `wb_rst_i` in 1: reset, synchronous and active-high.
- `wb_adr_i` in 32: byte offset is `wb_adr_i[MEM_AW+1:2]`, one memory byte per 32-bit word.
- `wb_dat_i` in 32: write data; only [7:0] is used.
- `wb_we_i`, `wb_cyc_i`, `wb_stb_i` in 1 each: Wishbone classic controls.
- `wb_dat_o` out 32: {24'd0, mem byte}.
- `wb_ack_o` out 1: registered ack.
- `scl_pad_i`, `sda_pad_i` in 1 each: bus inputs.
- `sda_pad_o` out 1: constant 0.
- `sda_padoen_o` out 1: 1 releases SDA, 0 pulls it low.
- `irq_o` out 1: one-cycle pulse on a STOP that ends a write transfer which stored at least one data byte.

## Operation
- SCL and SDA each pass through a 2-flop synchronizer. Edges are detected on the synchronized values.
- START is SDA falling while SCL is high. STOP is SDA rising while SCL is high. Both are recognised in every state.
- START, including a repeated START, goes to ADDR and clears the bit counter.
- STOP goes to IDLE and releases SDA.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP.
- ADDR:
  - Shifts 8 bits, MSB first, on SCL rising edges.
  - If bits [7:1] equal SLAVE_ADDR, go to ADDR_ACK. Otherwise go to WAIT_STOP with SDA released.
  - Bit 0 (R/W) selects the data phase.
- ADDR_ACK / WR_ACK:
  - Drive SDA low from the SCL fall after the 8th bit until the next SCL fall.
  - Then go to WR_BYTE (write) or RD_BYTE (read).
- WR_BYTE:
  - The first byte after the address sets `ptr`.
  - Each later byte is written to mem[ptr], then ptr increments.
- RD_BYTE:
  - Loads mem[ptr] into the shift register at the SCL fall that ends the ACK.
  - Drives 8 bits MSB first, each changing on an SCL fall.
  - Increments ptr after the 8th bit.
- RD_ACK:
  - SDA is released.
  - SDA sampled low on SCL rise (ACK) returns to RD_BYTE.
  - SDA high (NACK) goes to WAIT_STOP.
- Pointer arithmetic is modulo 2^MEM_AW: ptr = 2^MEM_AW-1 wraps to 0.
- Writes always ACK; there is no NACK on data.
- Wishbone:
  - Read or write of mem[byte offset]; ack one cycle after stb & cyc, deasserted the following cycle.
  - If an I2C write commits in the same cycle, the I2C write takes the single write port. The Wishbone write is performed and acked one cycle later, so Wishbone data wins on the same address.
- Memory contents are not reset.

## Timing
- Reset values:
  - sda_padoen_o = 1, sda_pad_o = 0, wb_ack_o = 0, irq_o = 0, wb_dat_o = 0.
  - State IDLE, ptr = 0.
- Synchronized-edge latency is 2 cycles, plus 2 more with the filter (see Configuration).
- SDA is updated on the first cycle after a detected SCL fall. This requires wb_clk ≥ 16× SCL for the data hold margin.
- No clock stretching: SCL is never driven.
- Reset asserted mid-transfer releases SDA on the next edge. The bus master then sees a NACK or garbage bits.
- irq_o is asserted the cycle after STOP is detected.

## Configuration
- `I2C_SLAVE_GLITCH_FILTER_EN` defined: a 3-sample majority filter is added after the synchronizers on SCL and SDA. Each line's value changes only after 3 consecutive equal samples, which adds 2 cycles of latency.
- Undefined: 2-flop synchronizers only. Glitches shorter than one clock can create false edges.

## Test plan
- Address match: master writes 0xA0, 0x10, 0x5A, 0xC3 then STOP.
  - Every byte ACKed.
  - Wishbone reads at byte offsets 0x10 and 0x11 (wb_adr_i 0x40, 0x44) return 0x5A and 0xC3.
  - irq_o pulses once; ptr = 0x12.
- Read with repeated START: after Wishbone writes 0x77 at offset 0x20, master writes 0xA0, 0x20, then repeated START, 0xA1, reads 2 bytes (ACK, NACK).
  - Returns 0x77 then mem[0x21].
  - State reaches WAIT_STOP, then IDLE on STOP.
- Address mismatch: master sends 0xA2.
  - SDA stays released through the ACK slot; no memory change; no irq.
- Wrap: pointer write 0xFF, then data bytes 0x11, 0x22.
  - mem[0xFF] = 0x11, mem[0x00] = 0x22.
- Collision: Wishbone write 0x99 to offset 0x05 in the same cycle as an I2C commit of 0x44 to 0x05.
  - Wishbone ack is one cycle late; a final read returns 0x99.
- Reset mid-read: assert wb_rst_i during bit 3 of a read byte.
  - sda_padoen_o = 1 the next cycle.
  - A new START followed by 0xA0 is ACKed normally.
